// File: rtl/colune_scan_driver_pkg.sv
// Shared types and defaults for the LED matrix column scanner.
// Provides the column scan FSM encoding and the row pattern type.
package colune_pkg;

    localparam int DEF_DATA_WIDTH    = 28;
    localparam int DEF_COLUNE_SIZE   = 7;
    localparam int DEF_TOTAL_COLUNES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } colune_state_t;

    typedef logic [DEF_COLUNE_SIZE-1:0] pattern_t;

    // Counter/index width that never collapses to zero bits.
    function automatic int min1_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/colune_scan_driver_if.sv
// Frame handshake bundle between the column decoders and the scan driver.
interface colune_scan_driver_if
    import colune_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] frame_in;
    logic                  frame_valid;
    logic                  frame_ready;

    modport master (
        output frame_in,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  frame_in,
        input  frame_valid,
        output frame_ready
    );

endinterface

// File: rtl/colune_scan_prescaler.sv
// Dwell-time counter: counts while run is high and flags the terminal count.
// The counter restarts on its own after the terminal count or when cleared.
module colune_scan_prescaler
    import colune_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int               CNT_W    = min1_clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] count;

    assign tick = run && (count == TERMINAL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr || tick) begin
            count <= '0;
        end else if (run) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/colune_scan_driver.sv
// Time-multiplexed LED column scanner with a tear-free double-buffered frame.
// Optional inter-column blanking is compiled in with COLUNE_SCAN_BLANK_EN.
module colune_scan_driver
    import colune_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int COLUNE_SIZE   = DEF_COLUNE_SIZE,
    parameter int TOTAL_COLUNES = DEF_TOTAL_COLUNES,
    parameter int SCAN_DIV      = 50000,
    parameter int BLANK_CYCLES  = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    colune_scan_driver_if.slave      frm,
    output logic [TOTAL_COLUNES-1:0] colune_sel,
    output logic [COLUNE_SIZE-1:0]   row_out,
    output logic                     frame_done
);

    localparam int               COL_W    = min1_clog2(TOTAL_COLUNES);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(TOTAL_COLUNES - 1);

    if (DATA_WIDTH != COLUNE_SIZE * TOTAL_COLUNES || SCAN_DIV < 1 || BLANK_CYCLES < 1) begin : g_bad_params
        $error("colune_scan_driver: inconsistent frame geometry or dwell parameters");
    end

    colune_state_t state;
    colune_state_t state_nxt;

    logic [COL_W-1:0]         col;
    logic [COL_W-1:0]         col_nxt;
    logic [DATA_WIDTH-1:0]    pending;
    logic [DATA_WIDTH-1:0]    active;
    logic                     pending_full;
    logic                     accept;
    logic                     promote;
    logic                     wrap;
    logic                     scan_tick;
    logic [TOTAL_COLUNES-1:0] sel_d;
    logic [COLUNE_SIZE-1:0]   row_d;

    function automatic logic [COL_W-1:0] next_col(input logic [COL_W-1:0] c);
        return (c == LAST_COL) ? '0 : c + 1'b1;
    endfunction

    assign accept          = frm.frame_valid && !pending_full;
    assign frm.frame_ready = !pending_full;

    colune_scan_prescaler #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_presc (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state != SCAN),
        .run     (state == SCAN),
        .tick    (scan_tick)
    );

`ifdef COLUNE_SCAN_BLANK_EN
    logic blank_tick;

    colune_scan_prescaler #(
        .SCAN_DIV (BLANK_CYCLES)
    ) u_blank_presc (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state != BLANK),
        .run     (state == BLANK),
        .tick    (blank_tick)
    );
`endif

    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        promote   = 1'b0;
        wrap      = 1'b0;
        case (state)
            IDLE: begin
                col_nxt = '0;
                if (enable) begin
                    state_nxt = SCAN;
                    promote   = 1'b1;
                end
            end
            SCAN: begin
                if (scan_tick) begin
`ifdef COLUNE_SCAN_BLANK_EN
                    state_nxt = BLANK;
`else
                    col_nxt = next_col(col);
                    wrap    = (col == LAST_COL);
`endif
                end
            end
`ifdef COLUNE_SCAN_BLANK_EN
            BLANK: begin
                if (blank_tick) begin
                    state_nxt = SCAN;
                    col_nxt   = next_col(col);
                    wrap      = (col == LAST_COL);
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
                col_nxt   = '0;
            end
        endcase

        // Dropping enable overrides any advance; the next scan restarts at column 0.
        if (!enable) begin
            state_nxt = IDLE;
            col_nxt   = '0;
            promote   = 1'b0;
            wrap      = 1'b0;
        end
        promote = promote | wrap;

        // Enable gates the decode directly so the pins go dark one edge after it falls.
        sel_d = '1;
        row_d = '1;
        if (state == SCAN && enable) begin
            sel_d[col] = 1'b0;
            row_d      = active[col*COLUNE_SIZE +: COLUNE_SIZE];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            col          <= '0;
            pending_full <= 1'b0;
            active       <= '1;
            colune_sel   <= '1;
            row_out      <= '1;
            frame_done   <= 1'b0;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            // Only an unconsumed frame is promoted; active never changes mid-scan.
            if (promote && pending_full) begin
                active <= pending;
            end
            if (accept) begin
                pending_full <= 1'b1;
            end else if (promote) begin
                pending_full <= 1'b0;
            end
            colune_sel <= sel_d;
            row_out    <= row_d;
            frame_done <= wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pending <= frm.frame_in;
        end
    end

endmodule

// File: tb/tb_colune_scan_driver.sv
// Self-checking bench for colune_scan_driver against a scan-position reference model.
module tb_colune_scan_driver;

    localparam int DW = 28;
    localparam int CS = 7;
    localparam int TC = 4;
    localparam int SD = 4;
    localparam int BC = 2;
`ifdef COLUNE_SCAN_BLANK_EN
    localparam int BLK = BC;
`else
    localparam int BLK = 0;
`endif
    localparam int SLOT   = SD + BLK;
    localparam int PERIOD = TC * SLOT;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic [TC-1:0] colune_sel;
    logic [CS-1:0] row_out;
    logic          frame_done;

    colune_scan_driver_if #(.DATA_WIDTH(DW)) frm ();

    colune_scan_driver #(
        .DATA_WIDTH    (DW),
        .COLUNE_SIZE   (CS),
        .TOTAL_COLUNES (TC),
        .SCAN_DIV      (SD),
        .BLANK_CYCLES  (BC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .frm        (frm),
        .colune_sel (colune_sel),
        .row_out    (row_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int done_count = 0;

    // Reference model: position within the scan period as seen on the pins.
    bit            started;
    int            next_pos;
    logic [DW-1:0] act;
    logic [DW-1:0] pend_q[$];
    logic [DW-1:0] src_q[$];
    logic [TC-1:0] exp_sel;
    logic [CS-1:0] exp_row;
    logic          exp_done;

    function automatic void model_reset();
        started  = 1'b0;
        next_pos = 0;
        act      = '1;
        pend_q.delete();
        exp_sel  = '1;
        exp_row  = '1;
        exp_done = 1'b0;
    endfunction

    function automatic void model_edge();
        bit was_full;
        bit acc;
        bit prom;
        int pos;
        was_full = (pend_q.size() != 0);
        acc      = frm.frame_valid && !was_full;
        prom     = 1'b0;
        pos      = -1;
        if (!enable) begin
            started = 1'b0;
        end else if (!started) begin
            started  = 1'b1;
            next_pos = 0;
            prom     = 1'b1;
        end else begin
            pos      = next_pos;
            next_pos = (pos + 1) % PERIOD;
            if (pos == PERIOD - 1) prom = 1'b1;
        end
        exp_done = (pos == PERIOD - 1);
        exp_sel  = '1;
        exp_row  = '1;
        if (pos >= 0 && (pos % SLOT) < SD) begin
            exp_sel[pos / SLOT] = 1'b0;
            exp_row = act[(pos / SLOT) * CS +: CS];
        end
        if (prom && was_full) act = pend_q.pop_front();
        if (acc) begin
            pend_q.push_back(frm.frame_in);
            void'(src_q.pop_front());
        end
    endfunction

    task automatic check_outputs(input string tag);
        checks++;
        assert (colune_sel === exp_sel) else begin
            failures++;
            $error("FAIL %s colune_sel got=%b exp=%b", tag, colune_sel, exp_sel);
        end
        checks++;
        assert (row_out === exp_row) else begin
            failures++;
            $error("FAIL %s row_out got=%h exp=%h", tag, row_out, exp_row);
        end
        checks++;
        assert (frame_done === exp_done) else begin
            failures++;
            $error("FAIL %s frame_done got=%b exp=%b", tag, frame_done, exp_done);
        end
        checks++;
        assert (frm.frame_ready === (pend_q.size() == 0)) else begin
            failures++;
            $error("FAIL %s frame_ready got=%b exp=%b", tag, frm.frame_ready, (pend_q.size() == 0));
        end
        checks++;
        assert ($countones(~colune_sel) <= 1) else begin
            failures++;
            $error("FAIL %s one_hot colune_sel got=%b exp=at most one low", tag, colune_sel);
        end
    endtask

    task automatic step(input string tag);
        if (src_q.size() != 0) begin
            frm.frame_valid = 1'b1;
            frm.frame_in    = src_q[0];
        end else begin
            frm.frame_valid = 1'b0;
            frm.frame_in    = DW'($urandom());
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs(tag);
        if (frame_done === 1'b1) done_count++;
    endtask

    task automatic check_const(input string tag, input logic [TC-1:0] sel, input logic [CS-1:0] row);
        checks++;
        assert (colune_sel === sel && row_out === row) else begin
            failures++;
            $error("FAIL %s got=%b/%h exp=%b/%h", tag, colune_sel, row_out, sel, row);
        end
    endtask

    initial begin
        logic [DW-1:0] f;
        model_reset();
        frm.frame_valid = 1'b0;
        frm.frame_in    = '0;
        repeat (3) @(negedge clk);
        check_outputs("reset_init");
        reset_n = 1'b1;

        // Basic scan with the walking-bit frame, loaded before enabling.
        src_q.push_back({7'h01, 7'h02, 7'h04, 7'h08});
        step("load");
        step("load");
        enable = 1'b1;
        done_count = 0;
        for (int i = 0; i < 2 * PERIOD + 1; i++) step("basic");
        checks++;
        assert (done_count == 2) else begin
            failures++;
            $error("FAIL done_per_scan got=%0d exp=2", done_count);
        end

        // Back-to-back frames: the second waits for the next wrap.
        f = DW'($urandom()); src_q.push_back(f);
        f = DW'($urandom()); src_q.push_back(f);
        for (int i = 0; i < 2 * PERIOD + 4; i++) step("backpressure");
        checks++;
        assert (src_q.size() == 0) else begin
            failures++;
            $error("FAIL backpressure_drain got=%0d exp=0", src_q.size());
        end

        // Tear-free: new frame arrives during column 1.
        for (int i = 0; i < PERIOD + SLOT && !(started && next_pos / SLOT == 1 && next_pos % SLOT == 1); i++)
            step("align_col1");
        f = DW'($urandom()); src_q.push_back(f);
        for (int i = 0; i < PERIOD + SLOT; i++) step("tear_free");

        // Enable drop during column 2, then re-enable.
        for (int i = 0; i < PERIOD + SLOT && !(started && next_pos / SLOT == 2 && next_pos % SLOT == 1); i++)
            step("align_col2");
        enable = 1'b0;
        step("enable_drop");
        check_const("enable_drop_dark", 4'b1111, 7'h7F);
        step("disabled");
        step("disabled");
        enable = 1'b1;
        step("reenable");
        check_const("reenable_first", 4'b1111, 7'h7F);
        for (int i = 0; i < SD; i++) begin
            step("reenable_col0");
            checks++;
            assert (colune_sel === 4'b1110) else begin
                failures++;
                $error("FAIL reenable_col0 got=%b exp=1110", colune_sel);
            end
        end

        // Randomized traffic with occasional enable drops.
        for (int i = 0; i < 400; i++) begin
            enable = ($urandom_range(0, 24) != 0);
            if (src_q.size() == 0 && $urandom_range(0, 3) == 0) begin
                f = DW'($urandom());
                src_q.push_back(f);
            end
            step("random");
        end

        // Asynchronous reset mid-scan, observed before any clock edge.
        enable = 1'b1;
        for (int i = 0; i < SD + 2; i++) step("pre_reset");
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        src_q.delete();
        check_const("async_reset_pins", 4'b1111, 7'h7F);
        check_outputs("async_reset");
        frm.frame_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < PERIOD + 2; i++) step("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
